// File: rtl/sm83_fetch_queue_if.sv
// sm83_fetch_queue_if: memory-bus and decoder-side signals of the SM83 fetch stage.
// master: the fetch stage itself; slave: the memory/decoder/control environment.
interface sm83_fetch_queue_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_pc;
    logic        out_ready;
    logic [15:0] fetch_pc;

    modport master (
        output mem_rd, mem_addr, out_valid, out_data, out_pc, fetch_pc,
        input  mem_rdata, mem_ack, stall, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, out_valid, out_data, out_pc, fetch_pc,
        output mem_rdata, mem_ack, stall, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/sm83_fetch_queue.sv
// sm83_fetch_queue: SM83 byte-stream instruction fetch with a small tagged byte queue.
// Optional feature macro SM83_FETCH_PREFETCH_EN: two-entry queue with back-to-back reads;
// without it the queue holds a single byte and every read is followed by an idle cycle.
module sm83_fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    sm83_fetch_queue_if.master bus
);

`ifdef SM83_FETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StFlush} state_t;

    state_t        state_q;
    logic          mem_rd_q;
    logic [15:0]   mem_addr_q;
    logic [15:0]   fetch_pc_q;

    logic [7:0]    data_q [DEPTH];
    logic [15:0]   pc_q   [DEPTH];
    logic [7:0]    data_d [DEPTH];
    logic [15:0]   pc_d   [DEPTH];
    logic [7:0]    shift_data [DEPTH];
    logic [15:0]   shift_pc   [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] wr_idx;
    logic          push;
    logic          pop;
    logic          room;

    // A redirect discards both the head pop and any returning byte.
    assign pop    = (count_q != '0) && bus.out_ready && !bus.redirect;
    assign push   = (state_q == StReq) && bus.mem_ack && !bus.redirect;
    assign wr_idx = count_q - CW'(pop);
    // Room is judged after this cycle's push/pop, so an ack always finds a free slot.
    assign room   = (count_nxt < DEPTH_C);

    if (DEPTH > 1) begin : g_shift
        // Move every entry one slot toward the head; the tail slot keeps its old value.
        always_comb begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                shift_data[i] = data_q[i + 1];
                shift_pc[i]   = pc_q[i + 1];
            end
            shift_data[DEPTH-1] = data_q[DEPTH-1];
            shift_pc[DEPTH-1]   = pc_q[DEPTH-1];
        end
    end else begin : g_no_shift
        assign shift_data = data_q;
        assign shift_pc   = pc_q;
    end

    // Next queue contents: pop shifts toward the head, push lands behind the survivors.
    always_comb begin
        count_nxt = count_q + CW'(push) - CW'(pop);
        data_d    = pop ? shift_data : data_q;
        pc_d      = pop ? shift_pc : pc_q;
        if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (int'(wr_idx) == i) begin
                    data_d[i] = bus.mem_rdata;
                    pc_d[i]   = fetch_pc_q;
                end
            end
        end
    end

    // Queue storage; a redirect empties it in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= 8'h00;
                pc_q[i]   <= 16'h0000;
            end
        end else begin
            count_q <= bus.redirect ? '0 : count_nxt;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    // Request FSM with registered bus outputs. With a one-entry queue, room is never
    // left after a push, so REQ always falls back to IDLE after its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            fetch_pc_q <= RESET_PC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= bus.redirect_pc;
                    end else if (room && !bus.stall) begin
                        state_q    <= StReq;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= bus.redirect_pc;
                        if (bus.mem_ack) begin
                            state_q  <= StIdle;
                            mem_rd_q <= 1'b0;
                        end else begin
                            // The bus cannot abort; hold the old address until the ack.
                            state_q <= StFlush;
                        end
                    end else if (bus.mem_ack) begin
                        fetch_pc_q <= fetch_pc_q + 16'd1;
                        if (room && !bus.stall) begin
                            mem_addr_q <= fetch_pc_q + 16'd1;
                        end else begin
                            state_q  <= StIdle;
                            mem_rd_q <= 1'b0;
                        end
                    end
                end
                StFlush: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= bus.redirect_pc;
                    end
                    if (bus.mem_ack) begin
                        state_q  <= StIdle;
                        mem_rd_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    mem_rd_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.fetch_pc  = fetch_pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = data_q[0];
    assign bus.out_pc    = pc_q[0];

endmodule

// File: tb/tb_sm83_fetch_queue.sv
// tb_sm83_fetch_queue: directed stimulus with a byte scoreboard for sm83_fetch_queue.
module tb_sm83_fetch_queue;

`ifdef SM83_FETCH_PREFETCH_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int BUDGET = 100;

    logic clk;
    logic rst_n;
    sm83_fetch_queue_if bus ();

    sm83_fetch_queue u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_popped = 0;
    int n_acks = 0;
    int mem_wait = 0;
    int cyc = 0;
    logic [23:0] exp_q[$];
    int pop_cyc_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h00;
            16'h0001: return 8'h3E;
            16'h0002: return 8'h42;
            16'h0003: return 8'hC3;
            16'h0038: return 8'hF5;
            16'h0039: return 8'hE5;
            16'h0100: return 8'h00;
            16'h0101: return 8'hC3;
            16'h0150: return 8'hF3;
            16'h0151: return 8'h31;
            16'hFFFF: return 8'h76;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout, want event within %0d cycles", name, BUDGET);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [7:0] d, input logic [15:0] pc);
        exp_q.push_back({d, pc});
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        exp_q.delete();
        tick();
        bus.redirect = 1'b0;
    endtask

    task automatic wait_pops(input int target, input string name);
        int b = BUDGET;
        while (n_popped < target && b > 0) begin
            tick();
            b--;
        end
        if (n_popped < target) fail_now(name);
    endtask

    task automatic wait_mem(input logic [15:0] addr, input string name);
        int b = BUDGET;
        while (!(bus.mem_rd && bus.mem_addr == addr) && b > 0) begin
            tick();
            b--;
        end
        if (!(bus.mem_rd && bus.mem_addr == addr)) fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        int b = BUDGET;
        while (bus.mem_rd && b > 0) begin
            tick();
            b--;
        end
        if (bus.mem_rd) fail_now(name);
    endtask

    // Next request whose address differs from 'old'; fails on timeout.
    task automatic wait_new_req(input logic [15:0] old, input string name);
        int b = BUDGET;
        tick();
        while (!(bus.mem_rd && bus.mem_addr != old) && b > 0) begin
            tick();
            b--;
        end
        if (!(bus.mem_rd && bus.mem_addr != old)) fail_now(name);
    endtask

    // Memory model: acks after mem_wait cycles of mem_rd, data from mem_byte.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.mem_rd) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= mem_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_byte(bus.mem_addr);
                wcnt = 0;
                n_acks++;
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Monitor: every consumed head byte must match the next expected entry.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect) begin
                n_popped++;
                pop_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got %h@%h, want no byte",
                             bus.out_data, bus.out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop", 32'({bus.out_data, bus.out_pc}), 32'(e));
                end
            end
        end
    end

    initial begin
        int tgt;
        int rd_cycles;
        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.out_ready   = 1'b0;
        repeat (3) tick();

        check("rst_mem_rd",    32'(bus.mem_rd),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'h0000);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h00);
        check("rst_out_pc",    32'(bus.out_pc),    32'h0000);
        check("rst_fetch_pc",  32'(bus.fetch_pc),  32'h0000);

        // Release with decoder stalled: only D bytes may be fetched.
        rst_n = 1'b1;
        tick();
        check("first_req_rd",   32'(bus.mem_rd),   32'd1);
        check("first_req_addr", 32'(bus.mem_addr), 32'h0000);
        repeat (10) tick();
        check("full_acks",      32'(n_acks),        32'(D));
        check("full_mem_rd",    32'(bus.mem_rd),    32'd0);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        check("full_head",      32'({bus.out_data, bus.out_pc}), 32'h00_0000);

        exp_push(8'h00, 16'h0000);
        exp_push(8'h3E, 16'h0001);
        exp_push(8'h42, 16'h0002);
        pop_cyc_q.delete();
        tgt = n_popped + 3;
        bus.out_ready = 1'b1;
        wait_pops(tgt, "stream_pops");
        bus.out_ready = 1'b0;
        check("stream_gap01", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 32'((D == 2) ? 1 : 2));
        check("stream_gap12", 32'(pop_cyc_q[2] - pop_cyc_q[1]), 32'((D == 2) ? 1 : 2));
        wait_idle("stream_settle");

        // Redirect during a 3-wait read of 0x0003.
        mem_wait = 3;
        do_redirect(16'h0003);
        wait_mem(16'h0003, "req_0003");
        do_redirect(16'h0150);
        check("flush_rd",   32'(bus.mem_rd),   32'd1);
        check("flush_addr", 32'(bus.mem_addr), 32'h0003);
        exp_push(8'hF3, 16'h0150);
        exp_push(8'h31, 16'h0151);
        wait_new_req(16'h0003, "req_after_flush");
        check("after_flush_addr", 32'(bus.mem_addr), 32'h0150);
        tgt = n_popped + 2;
        bus.out_ready = 1'b1;
        wait_pops(tgt, "redir_pops");
        bus.out_ready = 1'b0;
        wait_idle("redir_settle");

        // Redirect coincident with an ack (and a pop when two entries exist).
        mem_wait = 0;
        do_redirect(16'h0030);
        bus.out_ready = 1'b1;
        begin
            int b = BUDGET;
            while (!(bus.mem_rd && (D == 1 || bus.out_valid)) && b > 0) begin
                tick();
                b--;
            end
            if (b == 0) fail_now("ack_pop_setup");
        end
        do_redirect(16'h0038);
        check("ackredir_valid", 32'(bus.out_valid), 32'd0);
        check("ackredir_rd",    32'(bus.mem_rd),    32'd0);
        exp_push(8'hF5, 16'h0038);
        exp_push(8'hE5, 16'h0039);
        tick();
        check("ackredir_req_rd",   32'(bus.mem_rd),   32'd1);
        check("ackredir_req_addr", 32'(bus.mem_addr), 32'h0038);
        tgt = n_popped + 2;
        wait_pops(tgt, "ackredir_pops");
        bus.out_ready = 1'b0;
        wait_idle("ackredir_settle");

        // Address wrap at 0xFFFF.
        do_redirect(16'hFFFF);
        exp_push(8'h76, 16'hFFFF);
        exp_push(8'h00, 16'h0000);
        tgt = n_popped + 2;
        bus.out_ready = 1'b1;
        wait_mem(16'hFFFF, "req_ffff");
        wait_new_req(16'hFFFF, "req_wrap");
        check("wrap_addr", 32'(bus.mem_addr), 32'h0000);
        wait_pops(tgt, "wrap_pops");
        bus.out_ready = 1'b0;
        wait_idle("wrap_settle");

        // Stall during an outstanding read.
        mem_wait = 3;
        do_redirect(16'h0100);
        wait_mem(16'h0100, "req_0100");
        bus.stall = 1'b1;
        exp_push(8'h00, 16'h0100);
        tgt = n_popped + 1;
        bus.out_ready = 1'b1;
        wait_idle("stall_done");
        rd_cycles = 0;
        repeat (6) begin
            tick();
            if (bus.mem_rd) rd_cycles++;
        end
        check("stall_no_rd", 32'(rd_cycles), 32'd0);
        wait_pops(tgt, "stall_pop");
        exp_push(8'hC3, 16'h0101);
        tgt = n_popped + 1;
        bus.stall = 1'b0;
        wait_new_req(16'h0100, "resume_req");
        check("resume_addr", 32'(bus.mem_addr), 32'h0101);
        wait_pops(tgt, "resume_pop");
        bus.out_ready = 1'b0;
        wait_idle("resume_settle");

        // Reset in the middle of a request.
        do_redirect(16'h0200);
        wait_mem(16'h0200, "req_0200");
        rst_n = 1'b0;
        #1;
        check("midrst_rd",       32'(bus.mem_rd),    32'd0);
        check("midrst_valid",    32'(bus.out_valid), 32'd0);
        check("midrst_fetch_pc", 32'(bus.fetch_pc),  32'h0000);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        check("postrst_rd",   32'(bus.mem_rd),   32'd1);
        check("postrst_addr", 32'(bus.mem_addr), 32'h0000);
        repeat (8) tick();
        check("exp_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
